// File: rtl/ram.sv
// Single-port synchronous RAM with registered, write-first read data.
// Asynchronous active-low reset clears every word and the output register.
module ram #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              res,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] dout_d;
  logic [DATA_W-1:0] rd_data;
  logic              in_range;

  assign in_range = ({1'b0, addr} < DEPTH_C);

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) rd_data = mem_q[i];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    dout_d = '0;
    if (in_range) begin
      if (wr) begin
        dout_d = din;
        for (int i = 0; i < DEPTH; i++) begin
          if (addr == ADDR_W'(i)) mem_d[i] = din;
        end
      end else begin
        dout_d = rd_data;
      end
    end
  end

  // Storage lives in flops so the async clear can reach every word.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      dout_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_ram.sv
// Directed testbench for ram: reset, write-first, retention,
// latency sweep, async reset and writes blocked under reset.
module tb_ram;

  logic       clk;
  logic       res;
  logic       wr;
  logic [4:0] addr;
  logic [8:0] din;
  logic [8:0] dout;

  int n_chk;
  int n_err;

  ram #(
    .DATA_W(9),
    .ADDR_W(5),
    .DEPTH (32)
  ) u_dut (
    .clk (clk),
    .res (res),
    .wr  (wr),
    .addr(addr),
    .din (din),
    .dout(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] got,
                     input logic [8:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input logic [4:0] a, input logic [8:0] d);
    wr = 1'b1; addr = a; din = d;
    step();
    wr = 1'b0;
  endtask

  task automatic do_rd(input logic [4:0] a);
    wr = 1'b0; addr = a;
    step();
  endtask

  logic [8:0] exp_v;

  initial begin
    n_chk = 0;
    n_err = 0;
    res = 1'b0; wr = 1'b0; addr = '0; din = '0;

    // 1: reset, then read
    step();
    step();
    chk("rst_dout", dout, 9'h000);
    res = 1'b1;
    din = 9'h099;
    do_rd(5'd4);
    chk("rd4_after_rst", dout, 9'h000);
    do_rd(5'd4);
    chk("rd4_unchanged", dout, 9'h000);

    // 2: write-first
    do_wr(5'd4, 9'h199);
    chk("wr4_first", dout, 9'h199);

    // 3: second write and retention
    do_wr(5'd5, 9'h1FF);
    chk("wr5_first", dout, 9'h1FF);
    do_rd(5'd4);
    chk("rd4", dout, 9'h199);
    do_rd(5'd5);
    chk("rd5", dout, 9'h1FF);
    for (int i = 0; i < 32; i++) begin
      if (i != 4 && i != 5) begin
        do_rd(5'(i));
        chk($sformatf("zero_%0d", i), dout, 9'h000);
      end
    end

    // 4: address sweep, 1-cycle latency
    for (int i = 0; i < 32; i++) begin
      exp_v = 9'((i * 9 + 1) % 512);
      do_wr(5'(i), exp_v);
    end
    do_rd(5'd0);
    chk("sweep_0", dout, 9'h001);
    for (int i = 1; i < 32; i++) begin
      wr = 1'b0; addr = 5'(i);
      #2;
      exp_v = 9'(((i - 1) * 9 + 1) % 512);
      chk($sformatf("sweep_hold_%0d", i), dout, exp_v);
      step();
      exp_v = 9'((i * 9 + 1) % 512);
      chk($sformatf("sweep_%0d", i), dout, exp_v);
    end
    chk("sweep_31_lit", dout, 9'h118);

    // back-to-back write then read same address
    do_wr(5'd9, 9'h0C3);
    do_rd(5'd9);
    chk("wr_then_rd", dout, 9'h0C3);

    // 5: asynchronous reset between edges
    do_rd(5'd4);
    chk("pre_async_rd4", dout, 9'h025);
    #2;
    res = 1'b0;
    #1;
    chk("async_dout", dout, 9'h000);
    #3;
    res = 1'b1;
    do_rd(5'd4);
    chk("post_async_rd4", dout, 9'h000);
    do_rd(5'd5);
    chk("post_async_rd5", dout, 9'h000);

    // 6: writes ignored while reset held
    res = 1'b0; wr = 1'b1; addr = 5'd7; din = 9'h0AA;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rst_hold_%0d", k), dout, 9'h000);
    end
    wr = 1'b0;
    res = 1'b1;
    do_rd(5'd7);
    chk("rd7_after_rst_wr", dout, 9'h000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ram.md
Name:
ram

Overview:
- Single-port synchronous RAM, 32 words x 9 bits by default.
- Serves as the general-purpose scratch/data store for the datapath.
- Writes on the clock edge when `wr` is high.
- Output `dout` is registered; it shows the addressed word one cycle later, with write-first behaviour.
- Asynchronous active-low reset clears the whole array and `dout`.

Parameters:
- DATA_W, 9, width of each word and of `din`/`dout`.
- ADDR_W, 5, width of `addr`.
- DEPTH, 32, number of implemented words. Must satisfy DEPTH <= 2^ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- res  input  1  reset, asynchronous, active-low (0 = reset asserted).
- wr  input  1  write enable; 1 = write `din` to `mem[addr]` at this edge.
- addr  input  ADDR_W  word address for both read and write.
- din  input  DATA_W  write data.
- dout  output  DATA_W  registered read data.

Behaviour:
- Storage: array `mem[0..DEPTH-1]` of DATA_W bits, plus the registered output `dout`.
- Reset assertion (`res` = 0):
  - Takes effect immediately, without waiting for a clock edge.
  - Sets every `mem` word to 0 and sets `dout` to 0.
  - While `res` = 0, all clock edges are ignored: no writes, and `dout` holds 0.
- Reset release: the first rising edge with `res` = 1 performs a normal cycle.
- Write (rising edge, `res` = 1, `wr` = 1, `addr` < DEPTH):
  - `mem[addr]` <= `din`.
  - `dout` <= `din` (write-first: new data is visible on `dout` after that edge).
- Read (rising edge, `res` = 1, `wr` = 0, `addr` < DEPTH):
  - `dout` <= `mem[addr]`.
  - Read latency is exactly 1 clock; `dout` is stable between edges.
- Out-of-range address (`addr` >= DEPTH; only possible when DEPTH < 2^ADDR_W):
  - Writes are ignored and no `mem` word changes.
  - `dout` <= 0.
- `dout` is updated every enabled edge. There is no hold or enable other than reset.
- Data `din` is stored bit-exact with no truncation. `din` wider than DATA_W is not applicable; the port is exactly DATA_W.
- Back-to-back writes to different addresses on consecutive edges are independent. Each word keeps its value until it is rewritten or reset.
- Write then read of the same address on the next edge returns the newly written value.
- Reset asserted mid-write:
  - Asynchronous clear wins.
  - The word being written ends at 0.
  - No partial write survives.
- Contents are retained indefinitely while `res` = 1 and `wr` = 0.
- No X propagation:
  - `addr` or `wr` containing X/Z is a bench error, not a design case.
  - The design must not rely on initial blocks for state; reset defines all state.

Test Plan:
1. Reset, then read: hold `res` = 0 for 2 edges, release. Read `addr` = 4 with `wr` = 0 and `din` = 9'h099 -> `dout` = 9'h000 one edge later, and `mem[4]` is unchanged.
2. Write-first: `addr` = 4, `wr` = 1, `din` = 9'h199 for one edge -> `dout` = 9'h199 after that edge.
3. Second write and retention:
   - Write `addr` = 5, `din` = 9'h1FF -> `dout` = 9'h1FF.
   - Then read `addr` = 4 with `wr` = 0 -> `dout` = 9'h199.
   - Then read `addr` = 5 -> `dout` = 9'h1FF.
   - Words 0-3 and 6-31 still read 9'h000.
4. Address sweep with 1-cycle latency: write `mem[i]` = i*9+1 (mod 512) for i = 0..31, then read i = 0..31 consecutively -> each value appears on `dout` exactly one edge after its address is presented; `addr` = 31 returns 9'h118.
5. Asynchronous reset mid-operation: after test 3, drop `res` to 0 between clock edges -> `dout` = 0 immediately, before the next edge. Release and read addresses 4 and 5 -> both return 9'h000.
6. Write with reset held: `res` = 0, `wr` = 1, `addr` = 7, `din` = 9'h0AA across 3 edges. Release and read `addr` = 7 -> 9'h000.
